// File: rtl/debounce_pkg.sv
// Shared types and constants for the edge debouncer.
// Holds the FSM state encoding and the qualification counter width.
package debounce_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } state_t;

endpackage

// File: rtl/db_counter.sv
// Qualification counter: synchronous clear / increment, terminal-count flag.
// o_tc is high when the count has reached STABLE_CYCLES-1.
module db_counter
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/edge_debounce.sv
// Level debouncer: a change on D is accepted after STABLE_CYCLES equal samples.
// Produces registered Q/nQ, one-cycle Rise/Fall pulses, Busy and an edge count.
//
// state | meaning
// LOW   | accepted level 0, no candidate change
// RISE  | qualifying a 0->1 change
// HIGH  | accepted level 1, no candidate change
// FALL  | qualifying a 1->0 change
module edge_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       nRst,
  input  logic       D,
  output logic       Q,
  output logic       nQ,
  output logic       Rise,
  output logic       Fall,
  output logic       Busy,
  output logic [7:0] EdgeCnt
);

  state_t r_state;
  state_t w_next_state;

  logic w_tc;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_rise;
  logic w_fall;

  logic       r_q;
  logic       r_rise;
  logic       r_fall;
  logic       r_busy;
  logic [7:0] r_edge_cnt;

  db_counter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_counter (
    .i_clk  (Clk),
    .i_rst_n(nRst),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_tc   (w_tc)
  );

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= LOW;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOW:  if (D)       w_next_state = RISE;
      RISE: if (!D)      w_next_state = LOW;
            else if (w_tc) w_next_state = HIGH;
      HIGH: if (!D)      w_next_state = FALL;
      FALL: if (D)       w_next_state = HIGH;
            else if (w_tc) w_next_state = LOW;
      default:           w_next_state = LOW;
    endcase
  end

  // Entering a qualifying state increments from zero, so the first sample counts as 1.
  always_comb begin
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_rise    = 1'b0;
    w_fall    = 1'b0;
    case (r_state)
      LOW:  w_cnt_inc = D;
      HIGH: w_cnt_inc = !D;
      RISE: begin
        if (!D) begin
          w_cnt_clr = 1'b1;
        end else if (w_tc) begin
          w_cnt_clr = 1'b1;
          w_rise    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      FALL: begin
        if (D) begin
          w_cnt_clr = 1'b1;
        end else if (w_tc) begin
          w_cnt_clr = 1'b1;
          w_fall    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_q        <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_busy     <= 1'b0;
      r_edge_cnt <= '0;
    end else begin
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_busy <= (w_next_state == RISE) || (w_next_state == FALL);
      if (w_rise) begin
        r_q <= 1'b1;
      end else if (w_fall) begin
        r_q <= 1'b0;
      end
      if (w_rise || w_fall) begin
        r_edge_cnt <= r_edge_cnt + 8'd1;
      end
    end
  end

  assign Q       = r_q;
  assign nQ      = ~r_q;
  assign Rise    = r_rise;
  assign Fall    = r_fall;
  assign Busy    = r_busy;
  assign EdgeCnt = r_edge_cnt;

endmodule

// File: tb/tb_edge_debounce.sv
// Directed plus randomized checks of edge_debounce against a run-length model.
module tb_edge_debounce;

  localparam int N = 4;

  logic       Clk;
  logic       nRst;
  logic       D;
  logic       Q;
  logic       nQ;
  logic       Rise;
  logic       Fall;
  logic       Busy;
  logic [7:0] EdgeCnt;

  int n_vec;
  int n_err;

  // Reference: accepted level plus length of the current run of samples that differ from it.
  bit       m_q;
  int       m_run;
  bit       m_rise;
  bit       m_fall;
  bit [7:0] m_cnt;

  edge_debounce #(.STABLE_CYCLES(N)) dut (
    .Clk    (Clk),
    .nRst   (nRst),
    .D      (D),
    .Q      (Q),
    .nQ     (nQ),
    .Rise   (Rise),
    .Fall   (Fall),
    .Busy   (Busy),
    .EdgeCnt(EdgeCnt)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  function automatic void model_reset();
    m_q    = 1'b0;
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_cnt  = 8'd0;
  endfunction

  function automatic void model_edge(bit d);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (d != m_q) begin
      m_run = m_run + 1;
      if (m_run == N) begin
        m_q    = d;
        m_rise = d;
        m_fall = !d;
        m_cnt  = m_cnt + 8'd1;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("Q",       {7'd0, Q},    {7'd0, m_q});
    check("nQ",      {7'd0, nQ},   {7'd0, !m_q});
    check("Rise",    {7'd0, Rise}, {7'd0, m_rise});
    check("Fall",    {7'd0, Fall}, {7'd0, m_fall});
    check("Busy",    {7'd0, Busy}, {7'd0, (m_run != 0)});
    check("EdgeCnt", EdgeCnt,      m_cnt);
  endtask

  // Called at a falling edge; drives D, lets one rising edge pass, checks at the next falling edge.
  task automatic cycle(input bit d);
    D = d;
    @(posedge Clk);
    if (nRst) model_edge(d);
    @(negedge Clk);
    check_all();
  endtask

  task automatic async_reset_check();
    #3 nRst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    D    = 1'b0;
    nRst = 1'b0;
    @(negedge Clk);
    check_all();

    // Reset held with D toggling: everything stays cleared.
    for (int i = 0; i < 6; i++) cycle(i[0]);
    nRst = 1'b1;

    // Clean rise with D held high.
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check("rise_edgecnt", EdgeCnt, 8'd1);
    check("rise_q", {7'd0, Q}, 8'd1);

    // Short low glitch from HIGH.
    for (int i = 0; i < N - 1; i++) cycle(1'b0);
    cycle(1'b1);
    check("glitch_edgecnt", EdgeCnt, 8'd1);

    // Clean fall.
    for (int i = 0; i < 6; i++) cycle(1'b0);
    check("fall_edgecnt", EdgeCnt, 8'd2);

    // Short high glitch from LOW.
    for (int i = 0; i < N - 1; i++) cycle(1'b1);
    cycle(1'b0);

    // Randomized D with long-ish runs.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cycle(!D);
      else cycle(D);
    end

    // 256 accepted edges from reset wrap EdgeCnt back to 0.
    @(negedge Clk);
    async_reset_check();
    nRst = 1'b1;
    for (int e = 0; e < 256; e++) begin
      for (int k = 0; k < N; k++) cycle(~e[0]);
    end
    check("wrap_edgecnt", EdgeCnt, 8'd0);
    check("wrap_q_parity", {7'd0, Q}, 8'd0);

    // Reset mid-qualification aborts it; D=1 at release needs a full qualification.
    for (int i = 0; i < 2; i++) cycle(1'b1);
    async_reset_check();
    cycle(1'b1);
    nRst = 1'b1;
    for (int i = 0; i < N - 1; i++) cycle(1'b1);
    check("rel_q_before", {7'd0, Q}, 8'd0);
    cycle(1'b1);
    check("rel_q_at_n", {7'd0, Q}, 8'd1);
    check("rel_rise_at_n", {7'd0, Rise}, 8'd1);
    cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
